sspim_fifo_master: RTL

Parametrised SPI master engine with byte-wide TX/RX FIFOs, N chip selects and SPI modes 0-3.
- Runs multi-byte frames (1-256 bytes) under a single CS assertion, with no per-byte CPU handshake.
- Sits between a register/DMA front end and the SPI pads; successor to the single-word sspim datapath.

---
 rtl/sspim_pkg.sv | 40 ++++
 rtl/sspim_sfifo.sv | 53 +++++
 rtl/sspim_fifo_master.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/sspim_pkg.sv
// Shared types for the SPI FIFO master: FSM states, SPI mode encodings, latched frame config.
package sspim_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SETUP = 2'd1,
      ST_XFER  = 2'd2,
      ST_HOLD  = 2'd3
   } state_e;

   // {cpol, cpha}
   localparam logic [1:0] MODE0 = 2'b00;
   localparam logic [1:0] MODE1 = 2'b01;
   localparam logic [1:0] MODE2 = 2'b10;
   localparam logic [1:0] MODE3 = 2'b11;

   // Widest supported sck divider; narrower DIV_W values are zero-extended.
   localparam int MAX_DIV_W = 16;

   typedef struct packed {
      logic                 cpol;
      logic                 cpha;
      logic                 lsb_first;
      logic [MAX_DIV_W-1:0] sck_div;
      logic [3:0]           cs_gap;
      logic [2:0]           cs_sel;
      logic                 rx_en;
      logic                 loopback;
      logic [7:0]           len;
   } cfg_t;

   function automatic logic first_bit(input logic [7:0] d, input logic lsb);
      return lsb ? d[0] : d[7];
   endfunction

   function automatic logic [7:0] shift_out(input logic [7:0] d, input logic lsb);
      return lsb ? {1'b0, d[7:1]} : {d[6:0], 1'b0};
   endfunction

endpackage

// File: rtl/sspim_sfifo.sv
// Synchronous FIFO, combinational head read; writes when full and reads when empty are dropped.
module sspim_sfifo #(
   parameter int  WD    = 8,
   parameter int  DEPTH = 8,
   localparam int AW    = $clog2(DEPTH),
   localparam int LVL_W = AW + 1
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             wr_i,
   input  logic [WD-1:0]    wdata_i,
   input  logic             rd_i,
   output logic [WD-1:0]    rdata_o,
   output logic             full_o,
   output logic             empty_o,
   output logic [LVL_W-1:0] level_o
);

   logic [WD-1:0]    mem_q [DEPTH];
   logic [AW-1:0]    wptr_q;
   logic [AW-1:0]    rptr_q;
   logic [LVL_W-1:0] level_q;
   logic             do_wr;
   logic             do_rd;

   assign full_o  = (level_q == LVL_W'(DEPTH));
   assign empty_o = (level_q == '0);
   assign do_wr   = wr_i & ~full_o;
   assign do_rd   = rd_i & ~empty_o;
   assign rdata_o = mem_q[rptr_q];
   assign level_o = level_q;

   always_ff @(posedge clk) begin
      if (do_wr) mem_q[wptr_q] <= wdata_i;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         level_q <= '0;
      end else begin
         if (do_wr) wptr_q <= wptr_q + AW'(1);
         if (do_rd) rptr_q <= rptr_q + AW'(1);
         case ({do_wr, do_rd})
            2'b10:   level_q <= level_q + LVL_W'(1);
            2'b01:   level_q <= level_q - LVL_W'(1);
            default: level_q <= level_q;
         endcase
      end
   end

endmodule

// File: rtl/sspim_fifo_master.sv
// SPI master running 1-256 byte frames from a TX FIFO into an RX FIFO under one chip select.
// Define SSPIM_LOOPBACK_EN to allow an internal so->si path selected by cfg_loopback.
module sspim_fifo_master
   import sspim_pkg::*;
#(
   parameter int  NUM_CS     = 4,
   parameter int  FIFO_DEPTH = 8,
   parameter int  DIV_W      = 8,
   localparam int CS_W       = (NUM_CS > 1) ? $clog2(NUM_CS) : 1,
   localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              cfg_cpol,
   input  logic              cfg_cpha,
   input  logic              cfg_lsb_first,
   input  logic [DIV_W-1:0]  cfg_sck_div,
   input  logic [3:0]        cfg_cs_gap,
   input  logic [CS_W-1:0]   cfg_cs_sel,
   input  logic              cfg_rx_en,
   input  logic              cfg_loopback,
   input  logic              cmd_valid,
   input  logic [7:0]        cmd_len,
   output logic              cmd_ready,
   input  logic              tx_wr,
   input  logic [7:0]        tx_wdata,
   output logic              tx_full,
   output logic [LVL_W-1:0]  tx_level,
   input  logic              rx_rd,
   output logic [7:0]        rx_rdata,
   output logic              rx_empty,
   output logic [LVL_W-1:0]  rx_level,
   output logic              rx_ovf,
   input  logic              rx_ovf_clr,
   output logic              busy,
   output logic              done,
   output logic              sck,
   output logic              so,
   input  logic              si,
   output logic [NUM_CS-1:0] ssn
);

   state_e             state_q, state_d;
   cfg_t               cfg_q, cfg_d;
   logic               sck_q, sck_d, so_q, so_d, stall_q, stall_d, done_q, done_d, ovf_q;
   logic [NUM_CS-1:0]  ssn_q, ssn_d, ssn_sel;
   logic [DIV_W-1:0]   cnt_q, cnt_d;
   logic [3:0]         tog_q, tog_d, gap_q, gap_d;
   logic [7:0]         bcnt_q, bcnt_d, txsh_q, txsh_d, rxsh_q, rxsh_d;
   logic [7:0]         tx_rdata, rx_shifted, rx_wdat;
   logic               tx_empty, rx_full, tx_pop, rx_push, load, tc, odd_tog, last_tog, si_int;
   logic               cfg_unused;

`ifdef SSPIM_LOOPBACK_EN
   assign si_int = cfg_q.loopback ? so_q : si;
`else
   assign si_int = si;
`endif
   assign cfg_unused = ^{cfg_q.sck_div, cfg_q.loopback};

   sspim_sfifo #(.WD(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
      .clk(clk), .reset_n(reset_n), .wr_i(tx_wr), .wdata_i(tx_wdata), .rd_i(tx_pop),
      .rdata_o(tx_rdata), .full_o(tx_full), .empty_o(tx_empty), .level_o(tx_level)
   );

   sspim_sfifo #(.WD(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
      .clk(clk), .reset_n(reset_n), .wr_i(rx_push), .wdata_i(rx_wdat), .rd_i(rx_rd),
      .rdata_o(rx_rdata), .full_o(rx_full), .empty_o(rx_empty), .level_o(rx_level)
   );

   always_comb begin
      ssn_sel = '1;
      for (int i = 0; i < NUM_CS; i++) begin
         if (3'(cfg_cs_sel) == 3'(i)) ssn_sel[i] = 1'b0;
      end
   end

   // Toggle number is tog_q+1, so an odd toggle has tog_q[0]==0; toggle 16 closes the byte.
   assign tc         = (cnt_q == cfg_q.sck_div[DIV_W-1:0]);
   assign odd_tog    = ~tog_q[0];
   assign last_tog   = (tog_q == 4'd15);
   assign rx_shifted = cfg_q.lsb_first ? {si_int, rxsh_q[7:1]} : {rxsh_q[6:0], si_int};
   assign rx_wdat    = cfg_q.cpha ? rx_shifted : rxsh_q;

   always_comb begin
      state_d = state_q;  cfg_d  = cfg_q;  sck_d  = sck_q;  so_d   = so_q;
      ssn_d   = ssn_q;    cnt_d  = cnt_q;  tog_d  = tog_q;  bcnt_d = bcnt_q;
      gap_d   = gap_q;    txsh_d = txsh_q; rxsh_d = rxsh_q; stall_d = stall_q;
      done_d  = 1'b0;     tx_pop = 1'b0;   rx_push = 1'b0;  load   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            sck_d = cfg_cpol;
            if (cmd_valid) begin
               cfg_d.cpol      = cfg_cpol;
               cfg_d.cpha      = cfg_cpha;
               cfg_d.lsb_first = cfg_lsb_first;
               cfg_d.sck_div   = MAX_DIV_W'(cfg_sck_div);
               cfg_d.cs_gap    = cfg_cs_gap;
               cfg_d.cs_sel    = 3'(cfg_cs_sel);
               cfg_d.rx_en     = cfg_rx_en;
               cfg_d.loopback  = cfg_loopback;
               cfg_d.len       = cmd_len;
               ssn_d   = ssn_sel;
               gap_d   = '0;
               cnt_d   = '0;
               tog_d   = '0;
               bcnt_d  = '0;
               stall_d = 1'b0;
               state_d = ST_SETUP;
            end
         end
         ST_SETUP: begin
            if (gap_q != cfg_q.cs_gap) begin
               gap_d = gap_q + 4'd1;
            end else if (cfg_q.cpha) begin
               state_d = ST_XFER;
            end else if (!tx_empty) begin
               load    = 1'b1;
               state_d = ST_XFER;
            end
         end
         ST_XFER: begin
            if (stall_q) begin
               if (!tx_empty) begin
                  load    = 1'b1;
                  stall_d = 1'b0;
               end
            end else if (!tc) begin
               cnt_d = cnt_q + DIV_W'(1);
            end else if (!(cfg_q.cpha && tog_q == 4'd0 && tx_empty)) begin
               cnt_d = '0;
               sck_d = ~sck_q;
               tog_d = tog_q + 4'd1;
               if (cfg_q.cpha != odd_tog) rxsh_d = rx_shifted;
               if (cfg_q.cpha && tog_q == 4'd0) begin
                  load = 1'b1;
               end else if (cfg_q.cpha ? odd_tog : (!odd_tog && !last_tog)) begin
                  so_d   = first_bit(txsh_q, cfg_q.lsb_first);
                  txsh_d = shift_out(txsh_q, cfg_q.lsb_first);
               end
               if (last_tog) begin
                  rx_push = cfg_q.rx_en;
                  bcnt_d  = bcnt_q + 8'd1;
                  if (bcnt_q == cfg_q.len) begin
                     state_d = ST_HOLD;
                     gap_d   = '0;
                  end else if (!cfg_q.cpha) begin
                     if (!tx_empty) load = 1'b1;
                     else           stall_d = 1'b1;
                  end
               end
            end
         end
         ST_HOLD: begin
            if (gap_q != cfg_q.cs_gap) begin
               gap_d = gap_q + 4'd1;
            end else begin
               ssn_d   = '1;
               done_d  = 1'b1;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      if (load) begin
         tx_pop = 1'b1;
         so_d   = first_bit(tx_rdata, cfg_q.lsb_first);
         txsh_d = shift_out(tx_rdata, cfg_q.lsb_first);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE; cfg_q  <= '0;  sck_q  <= 1'b0; so_q    <= 1'b0;
         ssn_q   <= '1;      cnt_q  <= '0;  tog_q  <= '0;   bcnt_q  <= '0;
         gap_q   <= '0;      txsh_q <= '0;  rxsh_q <= '0;   stall_q <= 1'b0;
         done_q  <= 1'b0;    ovf_q  <= 1'b0;
      end else begin
         state_q <= state_d; cfg_q  <= cfg_d;  sck_q  <= sck_d;  so_q    <= so_d;
         ssn_q   <= ssn_d;   cnt_q  <= cnt_d;  tog_q  <= tog_d;  bcnt_q  <= bcnt_d;
         gap_q   <= gap_d;   txsh_q <= txsh_d; rxsh_q <= rxsh_d; stall_q <= stall_d;
         done_q  <= done_d;
         if (rx_push && rx_full) ovf_q <= 1'b1;
         else if (rx_ovf_clr)    ovf_q <= 1'b0;
      end
   end

   assign cmd_ready = (state_q == ST_IDLE);
   assign busy      = (state_q != ST_IDLE);
   assign done      = done_q;
   assign sck       = sck_q;
   assign so        = so_q;
   assign ssn       = ssn_q;
   assign rx_ovf    = ovf_q;

endmodule
